// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad front end: synchroniser, debounce FSM, key decode
// and a small key-code FIFO with a valid/ready consumer port.
module keypad_scan_fifo #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rin,
    input  logic [3:0] cin,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_e;

    logic [7:0]    sync1_q, sync2_q, latch_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          held_q;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q, rd_d;
    logic [PW:0]   count_q;
    logic [3:0]    code_q, head_d;
    logic          ovf_q;

    logic          s2_key, s2_zero, s2_same;
    logic          push, push_acc, pop, full, empty;
    logic [7:0]    src;
    logic [3:0]    push_code;

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        unique case (1'b1)
            v[0]:    r = 2'd0;
            v[1]:    r = 2'd1;
            v[2]:    r = 2'd2;
            v[3]:    r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Keypad legend: row0 1 2 3 A, row1 4 5 6 B, row2 7 8 9 C, row3 E 0 F D
    function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'hE;
            4'b11_01: k = 4'h0;
            4'b11_10: k = 4'hF;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    assign s2_key  = onehot4(sync2_q[7:4]) && onehot4(sync2_q[3:0]);
    assign s2_zero = (sync2_q == 8'd0);
    assign s2_same = (sync2_q == latch_q);

    // Single-cycle debounce pushes straight from the synchronised sample
    assign src       = (state_q == IDLE && s2_key) ? sync2_q : latch_q;
    assign push_code = decode(enc4(src[7:4]), enc4(src[3:0]));

    always_comb begin
        push = 1'b0;
        case (state_q)
            IDLE:      push = s2_key && (DEBOUNCE_CYCLES == 1);
            DEB_PRESS: push = s2_same && (cnt_q == CNT_LAST);
            default:   push = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {rin, cin};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            latch_q <= '0;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s2_key) begin
                        latch_q <= sync2_q;
                        cnt_q   <= CW'(1);
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= HELD;
                            held_q  <= 1'b1;
                        end else begin
                            state_q <= DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!s2_same) begin
                        state_q <= IDLE;
                    end else if (push) begin
                        state_q <= HELD;
                        held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (s2_zero) begin
                        cnt_q <= CW'(1);
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
                        end else begin
                            state_q <= DEB_REL;
                        end
                    end
                end
                default: begin
                    if (!s2_zero) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop      = !empty && key_ready;
    assign push_acc = push && (!full || pop);
    assign rd_d     = pop ? rd_q + PW'(1) : rd_q;
    // Next head is the incoming code when it lands exactly at the new read slot
    assign head_d   = (push_acc && rd_d == wr_q) ? push_code : mem_q[rd_d];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_acc) begin
                mem_q[wr_q] <= push_code;
                wr_q        <= wr_q + PW'(1);
            end
            rd_q    <= rd_d;
            count_q <= count_q + {{PW{1'b0}}, push_acc} - {{PW{1'b0}}, pop};
            code_q  <= head_d;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign key_code  = code_q;
    assign key_valid = !empty;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: reset, clean press, bounce,
// illegal pattern, FIFO overflow/ordering and reset while held.
module tb_keypad_scan_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] rin;
    logic [3:0] cin;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] ov_r [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000};
    logic [3:0] ov_c [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0010};
    logic [3:0] ov_k [4] = '{4'h1, 4'h2, 4'h3, 4'h5};

    keypad_scan_fifo #(
        .DEBOUNCE_CYCLES(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rin(rin),
        .cin(cin),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held(key_held),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rin = 4'(1 << (i % 4));
            cin = 4'(1 << ((i + 1) % 4));
            #1;
            total_cnt++;
            if ({key_valid, key_code, key_held, overflow} !== 7'b0)
                $display("FAIL reset_hold cyc=%0d got v=%b c=%h h=%b o=%b want all 0",
                         i, key_valid, key_code, key_held, overflow);
            else pass_cnt++;
        end
        @(negedge clk);
        rin = 4'd0;
        cin = 4'd0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({key_valid, key_code, key_held, overflow} !== 7'b0)
            $display("FAIL reset_release got v=%b c=%h h=%b o=%b want all 0",
                     key_valid, key_code, key_held, overflow);
        else pass_cnt++;
    endtask

    task automatic test_clean_press();
        key_ready = 1'b1;
        @(negedge clk);
        rin = 4'b0001;
        cin = 4'b0010;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            total_cnt++;
            if (key_valid !== (e == 3))
                $display("FAIL press_valid edge=%0d got %b want %b", e, key_valid, e == 3);
            else pass_cnt++;
            total_cnt++;
            if (key_held !== (e >= 3))
                $display("FAIL press_held edge=%0d got %b want %b", e, key_held, e >= 3);
            else pass_cnt++;
            if (e == 3) begin
                total_cnt++;
                if (key_code !== 4'h2)
                    $display("FAIL press_code got %h want 2", key_code);
                else pass_cnt++;
            end
        end
        rin = 4'd0;
        cin = 4'd0;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            total_cnt++;
            if ({key_valid, key_held} !== {1'b0, r < 3})
                $display("FAIL release r=%0d got v=%b h=%b want v=0 h=%b",
                         r, key_valid, key_held, r < 3);
            else pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        rin = 4'b0001;
        cin = 4'b0001;
        @(negedge clk);
        rin = 4'd0;
        cin = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({key_valid, key_held} !== 2'b00)
                $display("FAIL bounce cyc=%0d got v=%b h=%b want 0 0", i, key_valid, key_held);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        rin = 4'b0011;
        cin = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                rin = 4'd0;
                cin = 4'd0;
            end
            total_cnt++;
            if ({key_valid, key_held} !== 2'b00)
                $display("FAIL illegal cyc=%0d got v=%b h=%b want 0 0", i, key_valid, key_held);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        key_ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            rin = ov_r[p];
            cin = ov_c[p];
            repeat (5) @(negedge clk);
            rin = 4'd0;
            cin = 4'd0;
            repeat (5) @(negedge clk);
            total_cnt++;
            if (overflow !== (p == 4))
                $display("FAIL ovf_flag press=%0d got %b want %b", p, overflow, p == 4);
            else pass_cnt++;
            if (p == 0) begin
                total_cnt++;
                if ({key_valid, key_code} !== {1'b1, 4'h1})
                    $display("FAIL ovf_first got v=%b c=%h want v=1 c=1", key_valid, key_code);
                else pass_cnt++;
            end
        end
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({key_valid, key_code} !== {1'b1, ov_k[i]})
                $display("FAIL ovf_pop idx=%0d got v=%b c=%h want v=1 c=%h",
                         i, key_valid, key_code, ov_k[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (key_valid !== 1'b0)
            $display("FAIL ovf_drain got v=%b want 0", key_valid);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b1)
            $display("FAIL ovf_sticky got %b want 1", overflow);
        else pass_cnt++;
    endtask

    task automatic test_reset_held();
        key_ready = 1'b0;
        @(negedge clk);
        rin = 4'b0001;
        cin = 4'b0100;
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({key_valid, key_code, key_held} !== {1'b1, 4'h3, 1'b1})
            $display("FAIL rh_pre got v=%b c=%h h=%b want 1 3 1", key_valid, key_code, key_held);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({key_valid, key_code, key_held, overflow} !== 7'b0)
            $display("FAIL rh_async got v=%b c=%h h=%b o=%b want all 0",
                     key_valid, key_code, key_held, overflow);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            total_cnt++;
            if ({key_valid, key_held} !== {e >= 3, e >= 3})
                $display("FAIL rh_repress edge=%0d got v=%b h=%b want %b", e, key_valid, key_held, e >= 3);
            else pass_cnt++;
            if (e == 3) begin
                total_cnt++;
                if (key_code !== 4'h3)
                    $display("FAIL rh_code got %h want 3", key_code);
                else pass_cnt++;
            end
        end
        rin = 4'd0;
        cin = 4'd0;
        repeat (6) @(negedge clk);
        total_cnt++;
        if ({key_valid, key_code, key_held} !== {1'b1, 4'h3, 1'b0})
            $display("FAIL rh_release got v=%b c=%h h=%b want 1 3 0", key_valid, key_code, key_held);
        else pass_cnt++;
        key_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (key_valid !== 1'b0)
            $display("FAIL rh_single got v=%b want 0", key_valid);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (key_valid !== 1'b0)
            $display("FAIL rh_quiet got v=%b want 0", key_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        rin       = 4'd0;
        cin       = 4'd0;
        key_ready = 1'b1;
        #1 rst    = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_illegal();
        test_overflow();
        test_reset_held();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
